// File: rtl/cpu_req_pkg.sv
// cpu_req_pkg: command record and FSM states shared by cpu_req_master and its FIFO
package cpu_req_pkg;
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;
    typedef struct packed {
        logic                    rw;
        logic [CMD_ADDR_W-1:0]   addr;
        logic [CMD_DATA_W-1:0]   wdata;
        logic [CMD_DATA_W/8-1:0] wstrb;
        logic                    chk;
        logic [CMD_DATA_W-1:0]   exp;
    } cpu_cmd_t;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: read-pointer-plus-count FIFO of cpu_cmd_t entries
module cmd_fifo
    import cpu_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  cpu_cmd_t din,
    input  logic     pop,
    output cpu_cmd_t dout,
    output logic     full,
    output logic     empty
);
    localparam int PW = $clog2(DEPTH);
    cpu_cmd_t      mem_q [DEPTH];
    cpu_cmd_t      mem_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign full  = cnt_q == (PW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout  = mem_q[rd_q];
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr      = rd_q + cnt_q[PW-1:0];
        mem_d   = mem_q;
        if (do_push) mem_d[wr] = din;
        rd_d    = do_pop ? rd_q + PW'(1) : rd_q;
        cnt_d   = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/cpu_req_master.sv
// cpu_req_master: FIFO-fed L1 word-interface initiator with read checking and latency stats
module cpu_req_master
    import cpu_req_pkg::*;
#(
    parameter int ADDR_W    = CMD_ADDR_W,
    parameter int DATA_W    = CMD_DATA_W,
    parameter int CMD_DEPTH = 4,
    parameter int LAT_W     = 16,
    parameter int TIMEOUT   = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_rw,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    input  logic                cmd_chk,
    input  logic [DATA_W-1:0]   cmd_exp,
    output logic                cpu_req_valid,
    input  logic                cpu_req_ready,
    output logic                cpu_req_rw,
    output logic [ADDR_W-1:0]   cpu_addr,
    output logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W/8-1:0] cpu_wstrb,
    input  logic                cpu_resp_valid,
    input  logic [DATA_W-1:0]   cpu_rdata,
    output logic                busy,
    output logic [LAT_W-1:0]    done_cnt,
    output logic [LAT_W-1:0]    mismatch_cnt,
    output logic [LAT_W-1:0]    last_lat,
    output logic [LAT_W-1:0]    max_lat,
    output logic                err_timeout,
    output logic                err_spurious
);
    cpu_cmd_t         in_cmd, head, req_q, req_d;
    state_t           state_q, state_d;
    logic             fifo_empty, fifo_full, bypass;
    logic             valid_q, valid_d, err_to_q, err_to_d, err_sp_q, err_sp_d;
    logic [LAT_W-1:0] lat_q, lat_d, lat_inc, done_q, done_d, mis_q, mis_d;
    logic [LAT_W-1:0] last_q, last_d, max_q, max_d;

    function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
        return v == '1 ? v : v + LAT_W'(1);
    endfunction

    assign in_cmd = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb,
                      chk: cmd_chk, exp: cmd_exp};
    // An idle FSM with an empty FIFO takes the incoming command straight into the request registers
    assign bypass = state_q == IDLE && fifo_empty;

    cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && !bypass),
        .din   (in_cmd),
        .pop   (state_q == IDLE),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        valid_d  = valid_q;
        lat_d    = lat_q;
        done_d   = done_q;
        mis_d    = mis_q;
        last_d   = last_q;
        max_d    = max_q;
        err_to_d = err_to_q;
        err_sp_d = err_sp_q || (cpu_resp_valid && state_q != WAIT);
        lat_inc  = sat_inc(lat_q);
        if (state_q == IDLE) begin
            if (!fifo_empty || cmd_valid) begin
                req_d   = fifo_empty ? in_cmd : head;
                valid_d = 1'b1;
                state_d = REQ;
            end
        end else if (state_q == REQ) begin
            if (cpu_req_ready) begin
                valid_d = 1'b0;
                lat_d   = '0;
                state_d = WAIT;
            end
        end else begin
            lat_d = lat_inc;
            if (cpu_resp_valid) begin
                state_d = IDLE;
                last_d  = lat_inc;
                max_d   = lat_inc > max_q ? lat_inc : max_q;
                done_d  = sat_inc(done_q);
                if (!req_q.rw && req_q.chk && cpu_rdata != req_q.exp) mis_d = sat_inc(mis_q);
            end else if (lat_inc == LAT_W'(TIMEOUT)) begin
                err_to_d = 1'b1;
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= '0;
            valid_q  <= 1'b0;
            lat_q    <= '0;
            done_q   <= '0;
            mis_q    <= '0;
            last_q   <= '0;
            max_q    <= '0;
            err_to_q <= 1'b0;
            err_sp_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            lat_q    <= lat_d;
            done_q   <= done_d;
            mis_q    <= mis_d;
            last_q   <= last_d;
            max_q    <= max_d;
            err_to_q <= err_to_d;
            err_sp_q <= err_sp_d;
        end
    end

    assign cmd_ready     = !fifo_full;
    assign busy          = !fifo_empty || state_q != IDLE;
    assign cpu_req_valid = valid_q;
    assign cpu_req_rw    = req_q.rw;
    assign cpu_addr      = req_q.addr;
    assign cpu_wdata     = req_q.wdata;
    assign cpu_wstrb     = req_q.wstrb;
    assign done_cnt      = done_q;
    assign mismatch_cnt  = mis_q;
    assign last_lat      = last_q;
    assign max_lat       = max_q;
    assign err_timeout   = err_to_q;
    assign err_spurious  = err_sp_q;
endmodule

// File: tb/tb_cpu_req_master.sv
// tb_cpu_req_master: directed bench with a behavioural L1 responder (stall, latency, mute, stray pulse)
module tb_cpu_req_master;
    logic        clk = 0, rst = 0;
    logic        cmd_valid = 0, cmd_rw = 0, cmd_chk = 0;
    logic [31:0] cmd_addr = 0, cmd_wdata = 0, cmd_exp = 0;
    logic [3:0]  cmd_wstrb = 0;
    logic        cpu_req_ready = 0, cpu_resp_valid = 0;
    logic [31:0] cpu_rdata = 0;
    logic        cmd_ready, cpu_req_valid, cpu_req_rw, busy, err_timeout, err_spurious;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [15:0] done_cnt, mismatch_cnt, last_lat, max_lat;
    int          n_chk = 0, n_pass = 0;
    int          resp_lat = 3, stall_cycles = 0, f_wait;
    bit          mute = 0, spur_req = 0;
    logic [31:0] mem [logic [31:0]];

    cpu_req_master #(.CMD_DEPTH(4), .LAT_W(16), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_chk(cmd_chk),
        .cmd_exp(cmd_exp), .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_rw(cpu_req_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .busy(busy), .done_cnt(done_cnt),
        .mismatch_cnt(mismatch_cnt), .last_lat(last_lat), .max_lat(max_lat),
        .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    // Responder decides ready/response on the falling edge for the next rising edge
    initial begin
        int cnt, left;
        bit pending, seen;
        logic [31:0] rd, w;
        cnt = 0; left = 0; pending = 0; seen = 0; rd = 0; w = 0;
        forever begin
            @(negedge clk);
            cpu_resp_valid = spur_req;
            if (rst) begin
                pending = 0;
                seen = 0;
                cpu_req_ready = 0;
            end else begin
                if (pending) begin
                    cnt--;
                    if (cnt == 0) begin
                        pending = 0;
                        cpu_resp_valid = 1;
                        cpu_rdata = rd;
                    end
                end
                if (cpu_req_valid) begin
                    if (!seen) begin
                        seen = 1;
                        left = stall_cycles;
                    end
                    cpu_req_ready = left == 0;
                    if (left > 0) left--;
                    if (cpu_req_ready) begin
                        seen = 0;
                        w = mem.exists(cpu_addr) ? mem[cpu_addr] : 32'h0;
                        if (cpu_req_rw) begin
                            for (int b = 0; b < 4; b++)
                                if (cpu_wstrb[b]) w[8*b +: 8] = cpu_wdata[8*b +: 8];
                            mem[cpu_addr] = w;
                            rd = 0;
                        end else rd = w;
                        if (!mute) begin
                            pending = 1;
                            cnt = resp_lat;
                        end
                    end
                end else cpu_req_ready = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic rw, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic c, input logic [31:0] e);
        cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_chk = c; cmd_exp = e;
        cmd_valid = 1;
    endtask

    task automatic wait_ready(output int t);
        t = 0;
        while (!cmd_ready && t < 200) begin
            tick();
            t++;
        end
        if (!cmd_ready) check("push_bound", 32'(cmd_ready), 1);
    endtask

    task automatic push(input logic rw, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic c, input logic [31:0] e);
        int t;
        drive(rw, a, d, s, c, e);
        wait_ready(t);
        tick();
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 300) begin
            tick();
            t++;
        end
        check("idle_bound", 32'(busy), 0);
    endtask

    initial begin
        bit stable;
        #2 rst = 1;
        tick(3);
        rst = 0;
        tick();
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_valid", 32'(cpu_req_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done_cnt), 0);
        check("rst_mis", 32'(mismatch_cnt), 0);
        check("rst_errs", {30'd0, err_timeout, err_spurious}, 0);

        push(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0);
        check("wr_valid_n1", 32'(cpu_req_valid), 1);
        check("wr_payload", cpu_addr ^ cpu_wdata, 32'h100 ^ 32'hDEADBEEF);
        check("wr_rw", 32'(cpu_req_rw), 1);
        push(0, 32'h100, 0, 0, 1, 32'hDEADBEEF);
        wait_idle();
        check("t1_done", 32'(done_cnt), 2);
        check("t1_mis", 32'(mismatch_cnt), 0);
        check("t1_last", 32'(last_lat), 3);

        resp_lat = 7;
        push(0, 32'h200, 0, 0, 1, 32'h12345678);
        wait_idle();
        check("cold_mis", 32'(mismatch_cnt), 1);
        check("cold_last", 32'(last_lat), 7);
        check("cold_max", 32'(max_lat), 7);
        check("cold_done", 32'(done_cnt), 3);

        resp_lat = 2;
        push(0, 32'h100, 0, 0, 0, 32'hBAD);
        push(1, 32'h100, 32'h11223344, 4'b0101, 0, 0);
        push(0, 32'h100, 0, 0, 1, 32'hDE22BE44);
        wait_idle();
        check("mix_mis", 32'(mismatch_cnt), 1);
        check("mix_last", 32'(last_lat), 2);
        check("mix_max", 32'(max_lat), 7);
        check("mix_done", 32'(done_cnt), 6);

        stall_cycles = 10;
        push(1, 32'h300, 32'hA5A55A5A, 4'hC, 0, 0);
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(cpu_req_valid && cpu_addr == 32'h300 && cpu_wdata == 32'hA5A55A5A &&
                  cpu_wstrb == 4'hC && cpu_req_rw)) stable = 0;
        end
        check("stall_stable", 32'(stable), 1);
        check("stall_busy", 32'(busy), 1);
        tick();
        check("stall_hs_drop", 32'(cpu_req_valid), 0);
        stall_cycles = 0;
        wait_idle();
        check("stall_last", 32'(last_lat), 2);
        check("stall_done", 32'(done_cnt), 7);

        resp_lat = 1;
        stall_cycles = 40;
        push(0, 32'h400, 0, 0, 0, 0);
        tick(2);
        stall_cycles = 0;
        for (int i = 1; i <= 4; i++) push(0, 32'h400 + 32'(4 * i), 0, 0, 0, 0);
        check("full_ready", 32'(cmd_ready), 0);
        check("full_head", cpu_req_valid ? cpu_addr : 32'hFFFFFFFF, 32'h400);
        drive(0, 32'h414, 0, 0, 0, 0);
        wait_ready(f_wait);
        check("fifth_blocked", 32'(f_wait > 20), 1);
        check("fifth_after_pop", cpu_req_valid ? cpu_addr : 32'hFFFFFFFF, 32'h404);
        tick();
        cmd_valid = 0;
        wait_idle();
        check("fill_done", 32'(done_cnt), 13);
        check("fill_last", 32'(last_lat), 1);

        mute = 1;
        push(0, 32'h500, 0, 0, 0, 0);
        tick();
        check("to_hs", 32'(cpu_req_valid), 0);
        push(0, 32'h504, 0, 0, 0, 0);
        tick(18);
        check("to_before", 32'(err_timeout), 0);
        tick();
        check("to_set", 32'(err_timeout), 1);
        mute = 0;
        check("to_done", 32'(done_cnt), 13);
        tick();
        check("to_next", cpu_req_valid ? cpu_addr : 32'hFFFFFFFF, 32'h504);
        wait_idle();
        check("to_next_done", 32'(done_cnt), 14);
        check("to_sticky", 32'(err_timeout), 1);

        resp_lat = 20;
        push(1, 32'h600, 32'h0BADF00D, 4'hF, 0, 0);
        push(0, 32'h604, 0, 0, 0, 0);
        tick(3);
        rst = 1;
        tick(2);
        rst = 0;
        tick();
        check("mid_rst_cnts", 32'(done_cnt) | 32'(mismatch_cnt) | 32'(last_lat) | 32'(max_lat), 0);
        check("mid_rst_err", 32'(err_timeout), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(cmd_ready), 1);
        tick(5);
        check("mid_rst_quiet", 32'(cpu_req_valid), 0);

        check("spur_pre", 32'(err_spurious), 0);
        spur_req = 1;
        tick();
        spur_req = 0;
        check("spur_set", 32'(err_spurious), 1);
        check("spur_done", 32'(done_cnt), 0);
        resp_lat = 2;
        push(0, 32'h100, 0, 0, 1, 32'hDE22BE44);
        wait_idle();
        check("post_done", 32'(done_cnt), 1);
        check("post_mis", 32'(mismatch_cnt), 0);
        check("post_last", 32'(last_lat), 2);
        check("post_spur", 32'(err_spurious), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cpu_req_master.md
# cpu_req_master

Programmable CPU-side initiator for the L1 word interface of the cache hierarchy, driving the same `cpu_req_*` / `cpu_resp_*` protocol the L1 cache responds to. A testbench or on-chip self-test loader pushes load/store commands into a small FIFO. The block issues them one at a time, waits for each response, checks read data against an expected value and records latency statistics. It sits in place of the CPU in front of the L1 instance in bring-up and regression tops.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, word width; `DATA_W/8` strobe bits
- `CMD_DEPTH`, 4, command FIFO entries (power of two, ≥2)
- `LAT_W`, 16, width of latency and statistic counters
- `TIMEOUT`, 1000, cycles in WAIT before abandoning a request (< 2^LAT_W)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command push request
- `cmd_ready`  out  1  FIFO not full
- `cmd_rw`  in  1  0=read, 1=write
- `cmd_addr`  in  ADDR_W  word address
- `cmd_wdata`  in  DATA_W  write data
- `cmd_wstrb`  in  DATA_W/8  byte strobes
- `cmd_chk`  in  1  compare read data for this command
- `cmd_exp`  in  DATA_W  expected read data
- `cpu_req_valid`  out  1  request to L1
- `cpu_req_ready`  in  1  L1 accepts
- `cpu_req_rw`, `cpu_addr`, `cpu_wdata`, `cpu_wstrb`  out  1/ADDR_W/DATA_W/DATA_W/8  request payload
- `cpu_resp_valid`  in  1  L1 response, one per accepted request (reads and writes)
- `cpu_rdata`  in  DATA_W  read data
- `busy`  out  1  FIFO non-empty or FSM not IDLE
- `done_cnt`  out  LAT_W  completed requests
- `mismatch_cnt`  out  LAT_W  checked reads with `cpu_rdata != cmd_exp`
- `last_lat`, `max_lat`  out  LAT_W  latency of last / worst completed request
- `err_timeout`, `err_spurious`  out  1  sticky error flags

## Operation
- Push: entry written when `cmd_valid && cmd_ready`; `cmd_ready = !full`, based only on the current count. A push while full is refused even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the request registers, assert `cpu_req_valid`, go to REQ.
  - REQ: hold `cpu_req_valid` and the payload stable until `cpu_req_ready`. On handshake, drop valid, clear the latency counter and go to WAIT.
  - WAIT: increment the latency counter each cycle. On `cpu_resp_valid`, do the following and go to IDLE:
    - record `last_lat` and update `max_lat`
    - increment `done_cnt`
    - if the command was a read with `chk`, compare and increment `mismatch_cnt` on inequality
    - If the counter reaches `TIMEOUT` with no response, set `err_timeout`, count nothing and return to IDLE.
- `cpu_resp_valid` seen in IDLE or REQ sets `err_spurious` and is otherwise ignored.
- Counters saturate at 2^LAT_W−1 and do not wrap. Latency is the number of cycles from the cycle after the request handshake through the response cycle inclusive, so a response one cycle after acceptance gives latency 1.
- Reset (any time, including mid-request): FIFO emptied, FSM to IDLE, all outputs 0 except `cmd_ready`=1. An in-flight L1 transaction is abandoned; the L1 must be reset together with this block.

## Timing
- Command pushed at cycle N into an empty FIFO with FSM in IDLE: `cpu_req_valid` is high from cycle N+1 (registered).
- Request accepted at cycle M, response at cycle M+k: the counters update at the M+k edge and are visible from M+k+1. The next request's valid rises no earlier than M+k+1.
- Back-to-back throughput is one request per (accept + latency + 1) cycles. Only one request is outstanding at any time.
- All outputs are registered; there are no combinational paths from input to output except `cmd_ready` from the FIFO count register.

## Structure
- The package `cpu_req_pkg` holds the `cpu_cmd_t` struct (`rw`, `addr`, `wdata`, `wstrb`, `chk`, `exp`) and the FSM state enum `{IDLE, REQ, WAIT}`.
- Sub-module `cmd_fifo`: synchronous FIFO of `cpu_cmd_t`, parameter `DEPTH`, pointer plus count, with full/empty flags.

## Test plan
- Write `0xDEADBEEF` with strobe `4'hF` to `0x100`, then read `0x100` with chk and exp `0xDEADBEEF` → `done_cnt`=2, `mismatch_cnt`=0, `cpu_req_valid` rises 1 cycle after the first push.
- Read a cold address with chk and exp `0x12345678` when memory holds 0 → `mismatch_cnt`=1; `last_lat` equals the measured miss latency, `max_lat` ≥ `last_lat`.
- Hold `cpu_req_ready`=0 for 10 cycles → `cpu_req_valid` and payload stay stable throughout; latency counting starts only after the handshake.
- Push 5 commands with `CMD_DEPTH`=4 while the first is stalled → `cmd_ready`=0 after the 4th push, and the 5th is accepted only after the first pop.
- Stub responder that never answers, `TIMEOUT`=20 → `err_timeout`=1 exactly 20 cycles after acceptance, `done_cnt` unchanged, next command issued.
- Assert `rst` in WAIT; separately, pulse `cpu_resp_valid` in IDLE → after reset all counters are 0 and FIFO empty; the stray pulse sets `err_spurious`=1.
